// File: rtl/bin_to_bcd_seq_if.sv
// Handshake/data bundle for the sequential binary-to-BCD converter.
//   Start : request a conversion of Bin (master -> slave)
//   Bin   : unsigned binary value, WIDTH bits (master -> slave)
//   Busy  : converter is iterating (slave -> master)
//   Done  : one-cycle pulse, Bcd has just been updated (slave -> master)
//   Bcd   : packed BCD result, 4*DIGITS bits, ones digit in [3:0] (slave -> master)
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  Start;
  logic [WIDTH-1:0]      Bin;
  logic                  Busy;
  logic                  Done;
  logic [4*DIGITS-1:0]   Bcd;

  modport master (output Start, output Bin, input Busy, input Done, input Bcd);
  modport slave  (input Start, input Bin, output Busy, output Done, output Bcd);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double-dabble), one input
// bit per clock. The BCD result register is only written when a conversion
// completes, so the 7-segment decoders never see partial results.
//   Clk   : system clock, rising edge
//   Reset : synchronous, active-high; aborts any conversion and clears Bcd
//   bus   : slave side of bin_to_bcd_seq_if (Start/Bin in, Busy/Done/Bcd out)
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                    Clk,
  input  logic                    Reset,
  bin_to_bcd_seq_if.slave         bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CW    = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam longint unsigned P10  = pow10(DIGITS);
  localparam longint unsigned MAXV = (64'd1 << WIDTH) - 64'd1;

  // The digit field must be able to hold the largest input value.
  generate
    if (P10 <= MAXV) begin : g_digits_too_small
      $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
    end
  endgenerate

  // Every nibble that is 5..9 gets +3 so the following left shift carries
  // correctly into the next decimal digit. Nibbles never exceed 9 here, so
  // the 4-bit add cannot overflow.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] f);
    logic [BCD_W-1:0] r;
    r = f;
    for (int d = 0; d < DIGITS; d++) begin
      if (f[4*d +: 4] >= 4'd5) r[4*d +: 4] = f[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [BCD_W-1:0] bcd_q;
  logic [SR_W-1:0]  sreg;
  logic [SR_W-1:0]  sreg_nxt;
  logic             accept;
  logic             last;

  assign sreg_nxt = {add3(sreg[SR_W-1 -: BCD_W]), sreg[WIDTH-1:0]} << 1;
  // Start is honoured only when not iterating; a Start during SHIFT is dropped.
  assign accept   = bus.Start && (state != SHIFT);
  assign last     = (cnt == CW'(WIDTH - 1));

  // Control state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      bcd_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          cnt <= cnt + CW'(1);
          if (last) begin
            bcd_q <= sreg_nxt[SR_W-1 -: BCD_W];
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: shift register, loaded on accept and shifted while iterating
  always_ff @(posedge Clk) begin
    if (state == SHIFT) begin
      sreg <= sreg_nxt;
    end else if (accept) begin
      sreg <= {{BCD_W{1'b0}}, bus.Bin};
    end
  end

  assign bus.Busy = (state == SHIFT);
  assign bus.Done = (state == DONE);
  assign bus.Bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a 16-bit/5-digit instance and an
// 8-bit/3-digit instance share clock and reset. A countdown/arithmetic model
// predicts Busy, Done and Bcd every cycle; directed literal checks pin it.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.WIDTH(16), .DIGITS(5)) bus16 ();
  bin_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) bus8  ();

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (.Clk(clk), .Reset(rst), .bus(bus16.slave));
  bin_to_bcd_seq #(.WIDTH(8),  .DIGITS(3)) dut8  (.Clk(clk), .Reset(rst), .bus(bus8.slave));

  logic        start_a = 1'b0;
  logic [15:0] bin_a   = '0;
  logic        start_b = 1'b0;
  logic [7:0]  bin_b   = '0;

  assign bus16.Start = start_a;
  assign bus16.Bin   = bin_a;
  assign bus8.Start  = start_b;
  assign bus8.Bin    = bin_b;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int x;
    x = v;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Model: a conversion occupies exactly W busy cycles after acceptance,
  // then one Done cycle in which the new decimal value appears.
  int          m_left [2];
  bit          m_done [2];
  logic [19:0] m_bcd  [2];
  int          m_lat  [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_left[i] = 0;
        m_done[i] = 1'b0;
        m_bcd[i]  = '0;
      end else if (m_left[i] > 0) begin
        m_left[i] = m_left[i] - 1;
        m_done[i] = (m_left[i] == 0);
        if (m_left[i] == 0) m_bcd[i] = to_bcd(m_lat[i]);
      end else begin
        m_done[i] = 1'b0;
        if ((i == 0) ? start_a : start_b) begin
          m_lat[i]  = (i == 0) ? int'(bin_a) : int'(bin_b);
          m_left[i] = (i == 0) ? 16 : 8;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({bus16.Busy, bus16.Done, bus16.Bcd} !== {m_left[0] > 0, m_done[0], m_bcd[0]}) begin
        fails++;
        $display("FAIL cycle16 t=%0t busy/done/bcd got %b/%b/%h expected %b/%b/%h", $time,
                 bus16.Busy, bus16.Done, bus16.Bcd, m_left[0] > 0, m_done[0], m_bcd[0]);
      end
      tests++;
      if ({bus8.Busy, bus8.Done, bus8.Bcd} !== {m_left[1] > 0, m_done[1], m_bcd[1][11:0]}) begin
        fails++;
        $display("FAIL cycle8 t=%0t busy/done/bcd got %b/%b/%h expected %b/%b/%h", $time,
                 bus8.Busy, bus8.Done, bus8.Bcd, m_left[1] > 0, m_done[1], m_bcd[1][11:0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Pulse Start for one cycle on the selected instance, count Busy cycles
  // until Done shows (bounded).
  task automatic run(input int sel, input int v, output int nbusy, output bit ok);
    if (sel == 0) begin bin_a = 16'(v); start_a = 1'b1; end
    else          begin bin_b = 8'(v);  start_b = 1'b1; end
    tick(1);
    start_a = 1'b0;
    start_b = 1'b0;
    nbusy = 0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if ((sel == 0) ? bus16.Done : bus8.Done) begin ok = 1'b1; break; end
      if ((sel == 0) ? bus16.Busy : bus8.Busy) nbusy++;
      tick(1);
    end
  endtask

  task automatic wait_done16(output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      n++;
      if (bus16.Done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic count_done16(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      tick(1);
      if (bus16.Done) n++;
    end
  endtask

  initial begin
    int  nb;
    int  n;
    bit  ok;

    // Reset and idle hold
    tick(2);
    chk_en = 1'b1;
    chk("rst_busy", 32'(bus16.Busy), 32'd0);
    chk("rst_done", 32'(bus16.Done), 32'd0);
    chk("rst_bcd",  32'(bus16.Bcd),  32'h0);
    chk("rst_bcd8", 32'(bus8.Bcd),   32'h0);
    rst = 1'b0;
    tick(10);
    chk("idle_busy", 32'(bus16.Busy), 32'd0);
    chk("idle_bcd",  32'(bus16.Bcd),  32'h0);

    // Basic conversion and latency
    run(0, 1234, nb, ok);
    chk("c1234_done", 32'(ok), 32'd1);
    chk("c1234_busy", nb, 32'd16);
    chk("c1234_bcd",  32'(bus16.Bcd), 32'h01234);
    tick(1);
    chk("c1234_pulse", 32'(bus16.Done), 32'd0);
    chk("c1234_hold",  32'(bus16.Bcd),  32'h01234);

    // Extremes take the full path
    run(0, 0, nb, ok);
    chk("c0_busy", nb, 32'd16);
    chk("c0_bcd",  32'(bus16.Bcd), 32'h0);
    run(0, 65535, nb, ok);
    chk("cmax_busy", nb, 32'd16);
    chk("cmax_bcd",  32'(bus16.Bcd), 32'h65535);

    // Start during SHIFT is ignored; Bcd holds prior value
    bin_a = 16'd777; start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(4);
    bin_a = 16'd9; start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    chk("ign_hold", 32'(bus16.Bcd), 32'h65535);
    wait_done16(n, ok);
    chk("ign_done", 32'(ok), 32'd1);
    chk("ign_bcd",  32'(bus16.Bcd), 32'h00777);
    count_done16(25, n);
    chk("ign_no2nd", n, 32'd0);

    // Start held high: back-to-back every 17 cycles
    bin_a = 16'd42; start_a = 1'b1;
    wait_done16(n, ok);
    chk("b2b_gap1", n, 32'd17);
    chk("b2b_bcd1", 32'(bus16.Bcd), 32'h00042);
    bin_a = 16'd99;
    wait_done16(n, ok);
    start_a = 1'b0;
    chk("b2b_gap2", n, 32'd17);
    chk("b2b_bcd2", 32'(bus16.Bcd), 32'h00099);
    tick(20);

    // Reset mid-SHIFT aborts
    bin_a = 16'd500; start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(7);
    chk("abort_busy_pre", 32'(bus16.Busy), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_busy", 32'(bus16.Busy), 32'd0);
    chk("abort_done", 32'(bus16.Done), 32'd0);
    chk("abort_bcd",  32'(bus16.Bcd),  32'h0);
    count_done16(20, n);
    chk("abort_nodone", n, 32'd0);

    // 8-bit / 3-digit instance
    run(1, 255, nb, ok);
    chk("w8_done", 32'(ok), 32'd1);
    chk("w8_busy", nb, 32'd8);
    chk("w8_bcd",  32'(bus8.Bcd), 32'h255);
    run(1, 100, nb, ok);
    chk("w8_bcd100", 32'(bus8.Bcd), 32'h100);

    // Exhaustive sweep; per-cycle model comparison covers the values
    for (int v = 0; v < 256; v++) begin
      run(1, v, nb, ok);
      chk("sweep_done", 32'(ok), 32'd1);
    end
    tick(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
